// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that hands one shared serial line to N_REQ requesters.
// Each granted 7-bit word is framed as start, 7 data bits LSB first, parity and stop, followed by an idle gap.
module serial_tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter bit START_SIG  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int IDLE_GAP   = 1
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic [N_REQ-1:0]         req,
  input  logic [7*N_REQ-1:0]       data_in,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     s_out
);

  localparam int IW = $clog2(N_REQ);
  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP - 1);
  localparam logic [IW-1:0] LAST_REQ = IW'(N_REQ - 1);
  localparam logic          IDLE_LVL = ~START_SIG;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic [IW-1:0]   ptr_q;
  logic [6:0]      word_q;
  logic            parity_q;
  logic            s_out_d;
  logic            grant;

  logic [6:0]      words [N_REQ];
  logic            found;
  logic [IW-1:0]   winner;
  logic [IW-1:0]   idx_w;
  int              idx;
  logic [6:0]      win_word;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) words[i] = data_in[7*i +: 7];
  end

  // First set request scanning from the round-robin pointer upwards, with wrap.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    idx_w  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_w = IW'(idx);
      if (!found && req[idx_w]) begin
        found  = 1'b1;
        winner = idx_w;
      end
    end
    win_word = words[winner];
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    grant     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_START;
          grant   = 1'b1;
        end
      end
      S_START: begin
        state_d   = S_DATA;
        bit_cnt_d = '0;
      end
      S_DATA: begin
        if (bit_cnt_q == 3'd6) state_d = S_PARITY;
        else bit_cnt_d = bit_cnt_q + 3'd1;
      end
      S_PARITY: state_d = S_STOP;
      S_STOP: begin
        state_d   = S_GAP;
        gap_cnt_d = '0;
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // The line register is loaded with the level of the state being entered.
    case (state_d)
      S_START:  s_out_d = START_SIG;
      S_DATA:   s_out_d = word_q[bit_cnt_d];
      S_PARITY: s_out_d = parity_q;
      default:  s_out_d = IDLE_LVL;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rstN) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      ptr_q      <= '0;
      grant_id   <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      s_out      <= IDLE_LVL;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      busy       <= (state_d != S_IDLE);
      frame_done <= (state_q == S_STOP);
      s_out      <= s_out_d;
      ack        <= '0;
      if (grant) begin
        ack[winner] <= 1'b1;
        grant_id    <= winner;
        ptr_q       <= (winner == LAST_REQ) ? '0 : winner + 1'b1;
      end
    end
  end

  // NOTE: the captured word and parity are left unreset; they are only read after a grant loads them.
  always_ff @(posedge clk) begin
    if (grant) begin
      word_q   <= win_word;
      parity_q <= PARITY_ODD ^ (^win_word);
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: framing, round robin, parity, reset abort and a decoded loopback.
// A second instance runs with inverted start level, odd parity and a two-cycle gap.
module tb_serial_tx_arbiter;

  logic        clk = 1'b0;
  logic        rstN;
  logic [3:0]  req;
  logic [27:0] data_in;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy, frame_done, s_out;

  logic [1:0]  req2;
  logic [13:0] data2;
  logic [1:0]  ack2;
  logic [0:0]  gid2;
  logic        busy2, fd2, s2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;

  serial_tx_arbiter dut (
    .clk(clk), .rstN(rstN), .req(req), .data_in(data_in), .ack(ack),
    .grant_id(grant_id), .busy(busy), .frame_done(frame_done), .s_out(s_out)
  );

  serial_tx_arbiter #(.N_REQ(2), .START_SIG(1'b1), .PARITY_ODD(1'b1), .IDLE_GAP(2)) dut2 (
    .clk(clk), .rstN(rstN), .req(req2), .data_in(data2), .ack(ack2),
    .grant_id(gid2), .busy(busy2), .frame_done(fd2), .s_out(s2)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ack != 4'b0 && frame_done) viol++;
    if (!$onehot0(ack)) viol++;
    if (ack2 != 2'b0 && fd2) viol++;
    if (!$onehot0(ack2)) viol++;
  end

  // Receiver model for the default instance: idle-to-start edge, 7 data bits, parity, stop.
  int         dec_phase = 0;
  logic       dec_prev  = 1'b1;
  logic [6:0] dec_word;
  logic       dec_par;
  logic [6:0] rx_word [$];
  logic       rx_par  [$];
  logic       rx_stop [$];

  always @(negedge clk) begin
    if (!rstN) begin
      dec_phase = 0;
      dec_prev  = 1'b1;
    end else begin
      if (dec_phase == 0) begin
        if (dec_prev == 1'b1 && s_out == 1'b0) dec_phase = 1;
      end else if (dec_phase <= 7) begin
        dec_word[dec_phase-1] = s_out;
        dec_phase++;
      end else if (dec_phase == 8) begin
        dec_par   = s_out;
        dec_phase = 9;
      end else begin
        rx_word.push_back(dec_word);
        rx_par.push_back(dec_par);
        rx_stop.push_back(s_out);
        dec_phase = 0;
      end
      dec_prev = s_out;
    end
  end

  task automatic apply_reset();
    rstN = 1'b0;
    req  = '0;
    req2 = '0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic wait_ack(input int budget, output logic [3:0] a, output int at_cyc, output bit ok);
    ok = 1'b0;
    a = '0;
    at_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ack != 4'b0) begin
        a = ack;
        at_cyc = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (s_out !== 1'b1)    begin bad++; $display("FAIL reset_s_out got=%b exp=1", s_out); end
    total++; if (ack !== 4'b0)      begin bad++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    total++; if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    total++; if (s2 !== 1'b0)       begin bad++; $display("FAIL reset_s_out_inv got=%b exp=0", s2); end
  endtask

  task automatic test_single_frame();
    bit   exp_line [12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1, 1};
    logic eb, ef;
    logic [3:0] ea;
    apply_reset();
    data_in = {7'h2A, 7'h0F, 7'h70, 7'h55};
    req = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      eb = (k < 11);
      ef = (k == 10);
      ea = (k == 0) ? 4'b0001 : 4'b0000;
      total++; if (s_out !== exp_line[k]) begin bad++; $display("FAIL single_line[%0d] got=%b exp=%b", k, s_out, exp_line[k]); end
      total++; if (busy !== eb)       begin bad++; $display("FAIL single_busy[%0d] got=%b exp=%b", k, busy, eb); end
      total++; if (frame_done !== ef) begin bad++; $display("FAIL single_frame_done[%0d] got=%b exp=%b", k, frame_done, ef); end
      total++; if (ack !== ea)        begin bad++; $display("FAIL single_ack[%0d] got=%b exp=%b", k, ack, ea); end
      if (k == 0) begin
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL single_grant_id got=%0d exp=0", grant_id); end
        req = 4'b0000;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [6:0] wv [4] = '{7'h11, 7'h22, 7'h33, 7'h44};
    logic [3:0] a;
    int c, prev, base, eid;
    bit ok;
    apply_reset();
    data_in = {wv[3], wv[2], wv[1], wv[0]};
    base = rx_word.size();
    prev = 0;
    req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      eid = g % 4;
      wait_ack(20, a, c, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rr_ack_timeout grant=%0d got=none exp=ack", g); end
      else begin
        if (a !== 4'(1 << eid)) begin bad++; $display("FAIL rr_ack[%0d] got=%b exp=%b", g, a, 4'(1 << eid)); end
        total++; if (grant_id !== 2'(eid)) begin bad++; $display("FAIL rr_grant_id[%0d] got=%0d exp=%0d", g, grant_id, eid); end
        if (g > 0) begin
          total++; if (c - prev !== 12) begin bad++; $display("FAIL rr_period[%0d] got=%0d exp=12", g, c - prev); end
        end
      end
      prev = c;
    end
    req = 4'b0000;
    repeat (14) @(negedge clk);
    total++;
    if (rx_word.size() - base !== 5) begin bad++; $display("FAIL rr_frames got=%0d exp=5", rx_word.size() - base); end
    else begin
      for (int g = 0; g < 5; g++) begin
        total++; if (rx_word[base+g] !== wv[g % 4]) begin bad++; $display("FAIL rr_word[%0d] got=%h exp=%h", g, rx_word[base+g], wv[g % 4]); end
        total++; if (rx_par[base+g] !== ^wv[g % 4]) begin bad++; $display("FAIL rr_parity[%0d] got=%b exp=%b", g, rx_par[base+g], ^wv[g % 4]); end
      end
    end
  endtask

  task automatic test_pointer_rotation();
    int exp_id [3] = '{2, 3, 1};
    logic [3:0] next_req [3] = '{4'b1010, 4'b0010, 4'b0000};
    logic [3:0] a;
    int c;
    bit ok;
    apply_reset();
    data_in = {7'h04, 7'h03, 7'h02, 7'h01};
    req = 4'b0100;
    for (int g = 0; g < 3; g++) begin
      wait_ack(20, a, c, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rot_ack_timeout step=%0d got=none exp=ack", g); end
      else if (grant_id !== 2'(exp_id[g])) begin bad++; $display("FAIL rot_grant[%0d] got=%0d exp=%0d", g, grant_id, exp_id[g]); end
      req = next_req[g];
    end
    repeat (14) @(negedge clk);
  endtask

  task automatic test_odd_parity();
    logic [6:0] w;
    logic ep, es, eb, ef;
    logic [1:0] ea;
    apply_reset();
    data2 = {7'h00, 7'h7F};
    for (int p = 0; p < 2; p++) begin
      w  = (p == 0) ? 7'h7F : 7'h00;
      ep = (p == 0) ? 1'b0 : 1'b1;
      req2 = (p == 0) ? 2'b01 : 2'b10;
      for (int k = 0; k < 13; k++) begin
        @(negedge clk);
        if (k == 0) es = 1'b1;
        else if (k <= 7) es = w[k-1];
        else if (k == 8) es = ep;
        else es = 1'b0;
        eb = (k < 12);
        ef = (k == 10);
        ea = (k == 0) ? req2 : 2'b00;
        total++; if (s2 !== es)  begin bad++; $display("FAIL odd_line[%0d][%0d] got=%b exp=%b", p, k, s2, es); end
        total++; if (busy2 !== eb) begin bad++; $display("FAIL odd_busy[%0d][%0d] got=%b exp=%b", p, k, busy2, eb); end
        total++; if (fd2 !== ef) begin bad++; $display("FAIL odd_frame_done[%0d][%0d] got=%b exp=%b", p, k, fd2, ef); end
        total++; if (ack2 !== ea) begin bad++; $display("FAIL odd_ack[%0d][%0d] got=%b exp=%b", p, k, ack2, ea); end
        if (k == 0) begin
          total++; if (gid2 !== 1'(p)) begin bad++; $display("FAIL odd_grant_id[%0d] got=%0d exp=%0d", p, gid2, p); end
          req2 = 2'b00;
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] a;
    int c, base, fd_seen;
    bit ok;
    apply_reset();
    data_in = {7'h01, 7'h02, 7'h3C, 7'h6B};
    req = 4'b0001;
    wait_ack(20, a, c, ok);
    total++; if (!ok) begin bad++; $display("FAIL abort_first_ack got=none exp=ack"); end
    req = 4'b0000;
    base = rx_word.size();
    repeat (4) @(negedge clk);
    total++; if (s_out !== 1'b1) begin bad++; $display("FAIL abort_data_bit3 got=%b exp=1", s_out); end
    rstN = 1'b0;
    fd_seen = 0;
    @(negedge clk);
    total++; if (s_out !== 1'b1) begin bad++; $display("FAIL abort_s_out got=%b exp=1", s_out); end
    total++; if (busy !== 1'b0)  begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (ack !== 4'b0)   begin bad++; $display("FAIL abort_ack got=%b exp=0000", ack); end
    if (frame_done) fd_seen++;
    repeat (2) begin
      @(negedge clk);
      if (frame_done) fd_seen++;
    end
    rstN = 1'b1;
    req = 4'b0011;
    repeat (12) begin
      @(negedge clk);
      if (frame_done) fd_seen++;
      if (ack != 4'b0) break;
    end
    total++; if (fd_seen !== 0) begin bad++; $display("FAIL abort_frame_done got=%0d exp=0", fd_seen); end
    total++; if (grant_id !== 2'd0 || ack !== 4'b0001) begin bad++; $display("FAIL abort_ptr_reset got=%0d/%b exp=0/0001", grant_id, ack); end
    total++; if (rx_word.size() !== base) begin bad++; $display("FAIL abort_partial_frame got=%0d exp=%0d", rx_word.size(), base); end
    req = 4'b0010;
    wait_ack(20, a, c, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL abort_second_ack got=none exp=ack"); end
    else if (grant_id !== 2'd1) begin bad++; $display("FAIL abort_second_grant got=%0d exp=1", grant_id); end
    req = 4'b0000;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_loopback();
    logic [6:0] exp_w [20];
    logic [6:0] w;
    logic [3:0] a;
    int r, c, prev, base;
    bit ok;
    apply_reset();
    base = rx_word.size();
    prev = 0;
    for (int n = 0; n < 20; n++) begin
      r = int'($urandom_range(0, 3));
      w = 7'($urandom);
      data_in = 28'($urandom);
      data_in[7*r +: 7] = w;
      req = 4'(1 << r);
      exp_w[n] = w;
      wait_ack(30, a, c, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL loop_ack_timeout word=%0d got=none exp=ack", n); end
      else if (grant_id !== 2'(r)) begin bad++; $display("FAIL loop_grant[%0d] got=%0d exp=%0d", n, grant_id, r); end
      if (n > 0) begin
        total++; if (c - prev !== 12) begin bad++; $display("FAIL loop_period[%0d] got=%0d exp=12", n, c - prev); end
      end
      prev = c;
      req = 4'b0000;
    end
    repeat (14) @(negedge clk);
    total++;
    if (rx_word.size() - base !== 20) begin bad++; $display("FAIL loop_frames got=%0d exp=20", rx_word.size() - base); end
    else begin
      for (int n = 0; n < 20; n++) begin
        total++; if (rx_word[base+n] !== exp_w[n]) begin bad++; $display("FAIL loop_word[%0d] got=%h exp=%h", n, rx_word[base+n], exp_w[n]); end
        total++; if (rx_par[base+n] !== ^exp_w[n]) begin bad++; $display("FAIL loop_parity[%0d] got=%b exp=%b", n, rx_par[base+n], ^exp_w[n]); end
        total++; if (rx_stop[base+n] !== 1'b1)     begin bad++; $display("FAIL loop_stop[%0d] got=%b exp=1", n, rx_stop[base+n]); end
      end
    end
  endtask

  task automatic test_invariants();
    total++;
    if (viol !== 0) begin bad++; $display("FAIL ack_exclusive got=%0d exp=0", viol); end
  endtask

  initial begin
    rstN    = 1'b0;
    req     = '0;
    data_in = '0;
    req2    = '0;
    data2   = '0;
    test_reset();
    test_single_frame();
    test_round_robin();
    test_pointer_rotation();
    test_odd_parity();
    test_reset_mid_frame();
    test_loopback();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
